// File: rtl/mem_if.sv
// mem_if: byte-serial data-memory port; one byte per req/ack handshake.
//   req/wr/addr/wdata : request side, driven by the stage (master)
//   rdata/ack         : completion side, driven by the memory (slave)
interface mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            wdata;
  logic [7:0]            rdata;
  logic                  ack;
  modport master(output req, wr, addr, wdata, input rdata, ack);
  modport slave(input req, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RISC-V MEM stage running loads/stores over a byte-serial little-endian memory port.
//   clk, rst (async, active-low), stall : clock, reset, pipeline stall vector (bit 4 = MEM/WB)
//   exmem_*_in                          : EX/MEM register contents (address/result, rd, we, memop, store data)
//   mem                                 : byte-serial memory port (master side)
//   mem_res_out/mem_rdest_out/mem_we_out: writeback bundle for MEM/WB
//   stallreq_mem_out                    : held high while a transfer is in flight
module mem_stage #(
  parameter int ADDR_WIDTH  = 32,
  parameter int STALL_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WIDTH-1:0] stall,
  input  logic [31:0]            exmem_res_in,
  input  logic [4:0]             exmem_rdest_in,
  input  logic                   exmem_we_in,
  input  logic [3:0]             exmem_memop_in,
  input  logic [31:0]            exmem_sdata_in,
  mem_if.master                  mem,
  output logic [31:0]            mem_res_out,
  output logic [4:0]             mem_rdest_out,
  output logic                   mem_we_out,
  output logic                   stallreq_mem_out
);
  localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4, LHU = 4'd5;
  localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state, state_nxt;
  logic [1:0]            cnt;
  logic [1:0]            cnt_inc;
  logic [1:0]            last;
  logic [31:0]           data_buf;
  logic [31:0]           ld_val;
  logic [ADDR_WIDTH-1:0] base;
  logic                  is_load;
  logic                  is_store;
  logic                  hit;
  logic                  unused_stall;
  assign unused_stall  = ^{stall[STALL_WIDTH-1:5], stall[3:0]};
  assign is_load       = exmem_memop_in >= LB && exmem_memop_in <= LHU;
  assign is_store      = exmem_memop_in >= SB && exmem_memop_in <= SW;
  assign last          = (exmem_memop_in == LW || exmem_memop_in == SW) ? 2'd3 :
                         (exmem_memop_in == LH || exmem_memop_in == LHU || exmem_memop_in == SH) ? 2'd1 : 2'd0;
  assign cnt_inc       = cnt + 2'd1;
  assign base          = ADDR_WIDTH'(exmem_res_in);
  // an ack only counts against an outstanding request
  assign hit           = mem.req & mem.ack;
  assign mem_rdest_out = exmem_rdest_in;
  assign mem_we_out    = exmem_we_in;
  assign ld_val = exmem_memop_in == LB  ? {{24{data_buf[7]}}, data_buf[7:0]} :
                  exmem_memop_in == LH  ? {{16{data_buf[15]}}, data_buf[15:0]} :
                  exmem_memop_in == LBU ? {24'd0, data_buf[7:0]} :
                  exmem_memop_in == LHU ? {16'd0, data_buf[15:0]} : data_buf;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt        = state;
    stallreq_mem_out = 1'b0;
    mem_res_out      = exmem_res_in;
    case (state)
      IDLE: if (is_load || is_store) begin
        stallreq_mem_out = 1'b1;
        state_nxt        = BUSY;
      end
      BUSY: begin
        stallreq_mem_out = 1'b1;
        state_nxt        = (hit && cnt == last) ? DONE : BUSY;
      end
      DONE: begin
        mem_res_out = is_load ? ld_val : exmem_res_in;
        // leave only once MEM/WB captures, so the op is never restarted
        state_nxt   = stall[4] ? DONE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // request registers: the counter restarts only on IDLE->BUSY
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt       <= 2'd0;
      data_buf  <= 32'd0;
      mem.req   <= 1'b0;
      mem.wr    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= 8'd0;
    end else if (state == IDLE && (is_load || is_store)) begin
      cnt       <= 2'd0;
      mem.req   <= 1'b1;
      mem.wr    <= is_store;
      mem.addr  <= base;
      mem.wdata <= exmem_sdata_in[7:0];
    end else if (state == BUSY && hit) begin
      if (is_load) data_buf[{cnt, 3'b000} +: 8] <= mem.rdata;
      if (cnt == last) begin
        mem.req <= 1'b0;
        mem.wr  <= 1'b0;
      end else begin
        cnt       <= cnt_inc;
        mem.addr  <= base + ADDR_WIDTH'(cnt_inc);
        mem.wdata <= exmem_sdata_in[{cnt_inc, 3'b000} +: 8];
      end
    end
endmodule
